// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART RX FIFO control slice:
//   - fsm_state_e  : flush sequencer states
//   - FCR_*        : bit positions inside the FIFO control register write data
//   - trig_code_e  : RX trigger level codes (fcr_wdata[7:6])
//   - level_met()  : maps a trigger code onto the RX FIFO level flags
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_SETTLE = 2'd2
   } fsm_state_e;

   localparam int FCR_FIFO_EN  = 0;
   localparam int FCR_RX_RESET = 1;
   localparam int FCR_TX_RESET = 2;
   localparam int FCR_TRIG_LO  = 6;
   localparam int FCR_TRIG_HI  = 7;

   // The FIFO empty flag is registered inside the FIFO, so after the soft
   // reset drops it takes two cycles before the flags are trustworthy.
   localparam int SETTLE_CYCLES = 2;

   typedef enum logic [1:0] {
      TRIG_ONE  = 2'b00,
      TRIG_QTR  = 2'b01,
      TRIG_HALF = 2'b10,
      TRIG_ALM  = 2'b11
   } trig_code_e;

   function automatic logic level_met(input trig_code_e trig,
                                      input logic       empty,
                                      input logic       q_full,
                                      input logic       h_full,
                                      input logic       a_full);
      logic met;
      case (trig)
         TRIG_ONE:  met = ~empty;
         TRIG_QTR:  met = q_full;
         TRIG_HALF: met = h_full;
         TRIG_ALM:  met = a_full;
         default:   met = 1'b0;
      endcase
      return met;
   endfunction

endpackage

// File: rtl/uart_char_timeout.sv
// -----------------------------------------------------------------------------
// uart_char_timeout
// Counts character times of RX inactivity and raises cto_irq once CTO_CHARS
// ticks have passed with data still waiting in an enabled FIFO.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : clear the counter (push, pop, empty, FIFOs disabled, busy)
//   tick       : one-cycle pulse per character time
//   rxf_empty  : RX FIFO empty flag
//   fifo_en    : FIFO mode enabled
//   cto_irq    : registered character-timeout interrupt
// -----------------------------------------------------------------------------
module uart_char_timeout #(
   parameter int CTO_CHARS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   input  logic rxf_empty,
   input  logic fifo_en,
   output logic cto_irq
);

   localparam logic [3:0] CTO_MAX = 4'(CTO_CHARS);

   logic [3:0] count_q;
   logic [3:0] count_d;
   logic       cto_q;

   // Clear wins over tick in the same cycle; the count saturates at CTO_MAX.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 4'd0;
      end else if (tick && (count_q != CTO_MAX)) begin
         count_d = count_q + 4'd1;
      end
   end

   // Built from the next count so the interrupt rises right after the final
   // tick and drops in the cycle that follows a clearing event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 4'd0;
         cto_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         cto_q   <= (count_d == CTO_MAX) & ~clr & ~rxf_empty & fifo_en;
      end
   end

   assign cto_irq = cto_q;

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// FIFO control register handling, FIFO soft-reset sequencing, RX pop strobe
// and RX interrupt generation for a 16550-style UART.
// Optional feature: define UART_CHAR_TIMEOUT_EN to build the character timeout
// counter and cto_irq; otherwise cto_irq is tied low and char_tick is unused.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   fcr_we, fcr_wdata[7:0]    : FCR write (bit0 fifo_en, bit1 rx_reset,
//                               bit2 tx_reset, bits7:6 trigger code)
//   rbr_re                    : host read of the RX data register
//   rx_push                   : receiver pushed a character into the RX FIFO
//   char_tick                 : one pulse per character time
//   rxf_empty/q/h/a_full      : RX FIFO level flags
//   rxf_rd                    : RX FIFO pop strobe (combinational)
//   rxf_srst, txf_srst        : FIFO soft resets (registered)
//   fifo_en, trig_lvl         : stored FCR fields
//   rda_irq, cto_irq          : data-available / character-timeout interrupts
//   busy                      : flush sequence in progress
//   dbg_state                 : current sequencer state (fsm_state_e encoding)
// Handshake: rbr_re is a single-cycle request; it produces exactly one rxf_rd
// pulse in the same cycle when the FIFO holds data and no flush is running,
// and is dropped otherwise (no retry, no queuing).
// -----------------------------------------------------------------------------
module uart_rx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int SRST_CYCLES = 2,
   parameter int CTO_CHARS   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fcr_we,
   input  logic [7:0] fcr_wdata,
   input  logic       rbr_re,
   input  logic       rx_push,
   input  logic       char_tick,
   input  logic       rxf_empty,
   input  logic       rxf_q_full,
   input  logic       rxf_h_full,
   input  logic       rxf_a_full,
   output logic       rxf_rd,
   output logic       rxf_srst,
   output logic       txf_srst,
   output logic       fifo_en,
   output logic [1:0] trig_lvl,
   output logic       rda_irq,
   output logic       cto_irq,
   output logic       busy,
   output logic [1:0] dbg_state
);

   localparam logic [3:0] SRST_LAST   = 4'(SRST_CYCLES - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   fsm_state_e state_q;
   logic [3:0] cnt_q;
   logic       fifo_en_q;
   trig_code_e trig_q;
   logic       rxf_srst_q;
   logic       txf_srst_q;
   logic       pend_rx_q;
   logic       pend_tx_q;
   logic       rda_q;

   logic       wr_fen;
   logic       fen_chg;
   logic       explicit_rst;
   logic       req_rx;
   logic       req_tx;
   logic       is_idle;
   logic       lvl_met;

   assign wr_fen       = fcr_wdata[FCR_FIFO_EN];
   assign fen_chg      = fcr_we & (wr_fen != fifo_en_q);
   assign explicit_rst = fcr_wdata[FCR_RX_RESET] | fcr_wdata[FCR_TX_RESET];

   // Explicit reset bits choose which FIFOs get flushed. A write that only
   // toggles fifo_en (no reset bits set) flushes both FIFOs.
   assign req_rx = fcr_we & (fcr_wdata[FCR_RX_RESET] | (fen_chg & ~explicit_rst));
   assign req_tx = fcr_we & (fcr_wdata[FCR_TX_RESET] | (fen_chg & ~explicit_rst));

   assign is_idle = (state_q == ST_IDLE);
   assign lvl_met = level_met(trig_q, rxf_empty, rxf_q_full, rxf_h_full, rxf_a_full);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         fifo_en_q  <= 1'b0;
         trig_q     <= TRIG_ONE;
         rxf_srst_q <= 1'b0;
         txf_srst_q <= 1'b0;
         pend_rx_q  <= 1'b0;
         pend_tx_q  <= 1'b0;
         rda_q      <= 1'b0;
      end else begin
         if (fcr_we) begin
            fifo_en_q <= wr_fen;
            trig_q    <= trig_code_e'(fcr_wdata[FCR_TRIG_HI:FCR_TRIG_LO]);
         end

         rda_q <= (fifo_en_q ? lvl_met : ~rxf_empty) & is_idle;

         case (state_q)
            ST_IDLE: begin
               if (req_rx || req_tx) begin
                  state_q    <= ST_FLUSH;
                  cnt_q      <= SRST_LAST;
                  rxf_srst_q <= req_rx;
                  txf_srst_q <= req_tx;
               end
            end
            ST_FLUSH: begin
               // Commands arriving mid-flush are collected and replayed as a
               // fresh, full-length flush once this one has settled.
               pend_rx_q <= pend_rx_q | req_rx;
               pend_tx_q <= pend_tx_q | req_tx;
               if (cnt_q == 4'd0) begin
                  state_q    <= ST_SETTLE;
                  cnt_q      <= SETTLE_LAST;
                  rxf_srst_q <= 1'b0;
                  txf_srst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_SETTLE: begin
               if (cnt_q != 4'd0) begin
                  cnt_q     <= cnt_q - 4'd1;
                  pend_rx_q <= pend_rx_q | req_rx;
                  pend_tx_q <= pend_tx_q | req_tx;
               end else if (pend_rx_q || pend_tx_q || req_rx || req_tx) begin
                  state_q    <= ST_FLUSH;
                  cnt_q      <= SRST_LAST;
                  rxf_srst_q <= pend_rx_q | req_rx;
                  txf_srst_q <= pend_tx_q | req_tx;
                  pend_rx_q  <= 1'b0;
                  pend_tx_q  <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               rxf_srst_q <= 1'b0;
               txf_srst_q <= 1'b0;
            end
         endcase
      end
   end

   // Gated by rst so no pop escapes while the block is held in reset.
   assign rxf_rd    = rbr_re & ~rxf_empty & is_idle & ~rst;
   assign rxf_srst  = rxf_srst_q;
   assign txf_srst  = txf_srst_q;
   assign fifo_en   = fifo_en_q;
   assign trig_lvl  = trig_q;
   assign rda_irq   = rda_q;
   assign busy      = ~is_idle;
   assign dbg_state = state_q;

   // FCR bits 5:3 carry no function in this block.
   logic unused_fcr;
   assign unused_fcr = ^fcr_wdata[5:3];

`ifdef UART_CHAR_TIMEOUT_EN
   logic cto_clr;
   assign cto_clr = rx_push | rxf_rd | rxf_empty | ~fifo_en_q | ~is_idle;

   uart_char_timeout #(
      .CTO_CHARS (CTO_CHARS)
   ) u_cto (
      .clk       (clk),
      .rst       (rst),
      .clr       (cto_clr),
      .tick      (char_tick),
      .rxf_empty (rxf_empty),
      .fifo_en   (fifo_en_q),
      .cto_irq   (cto_irq)
   );
`else
   logic unused_cto_in;
   assign unused_cto_in = char_tick ^ rx_push;
   assign cto_irq       = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo_ctrl.md
UART_RX_FIFO_CTRL -- requirements
Module: uart_rx_fifo_ctrl

Interface
REQ-001 SHALL have parameter SRST_CYCLES, default 2: cycles each FIFO soft-reset pulse is held; legal range 2..15.
REQ-002 SHALL have parameter CTO_CHARS, default 4: character times of RX inactivity before character timeout; legal range 1..15.
REQ-003 SHALL have clk  in  1  single clock for all logic; FIFO read port is on this clock.
REQ-004 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have fcr_we  in  1  FIFO-control-register write strobe.
REQ-006 SHALL have fcr_wdata  in  8  bit0 fifo_en, bit1 rx_reset, bit2 tx_reset, bits7:6 trigger code.
REQ-007 SHALL have rbr_re  in  1  host read strobe of the RX data register.
REQ-008 SHALL have rx_push  in  1  receiver wrote one character into the RX FIFO.
REQ-009 SHALL have char_tick  in  1  one-cycle pulse per character time.
REQ-010 SHALL have rxf_empty, rxf_q_full, rxf_h_full, rxf_a_full  in  1 each  RX FIFO level flags.
REQ-011 SHALL have rxf_rd  out  1  RX FIFO read (pop) strobe.
REQ-012 SHALL have rxf_srst, txf_srst  out  1 each  FIFO soft resets (to rc_srst).
REQ-013 SHALL have fifo_en  out  1, trig_lvl  out  2, rda_irq  out  1, cto_irq  out  1, busy  out  1.

Function
REQ-014 SHALL register fifo_en and trig_lvl from fcr_wdata on fcr_we; rx_reset and tx_reset bits are self-clearing commands, not stored.
REQ-015 SHALL run FSM IDLE -> FLUSH -> SETTLE -> IDLE; busy = state != IDLE.
REQ-016 SHALL enter FLUSH from IDLE the cycle after fcr_we with rx_reset=1, tx_reset=1, or fifo_en bit differing from the stored fifo_en; fifo_en change flushes both FIFOs.
REQ-017 SHALL in FLUSH assert rxf_srst and/or txf_srst (per requesting command) for exactly SRST_CYCLES cycles, then go to SETTLE.
REQ-018 SHALL hold SETTLE for 2 cycles (registered FIFO empty flag) then return to IDLE.
REQ-019 SHALL OR an fcr_we received during FLUSH/SETTLE into the pending flush set and restart FLUSH with a full SRST_CYCLES count once SETTLE ends.
REQ-020 SHALL drive rxf_rd = rbr_re & ~rxf_empty & (state==IDLE), combinational, one pop per strobe; rbr_re on empty FIFO or while busy is ignored.
REQ-021 SHALL compute level_met: trig 00 ~rxf_empty, 01 rxf_q_full, 10 rxf_h_full, 11 rxf_a_full.
REQ-022 SHALL register rda_irq = (fifo_en ? level_met : ~rxf_empty) & ~busy, one cycle latency from flag change.
REQ-023 SHALL clear the timeout counter on rx_push, rxf_rd, rxf_empty, ~fifo_en, or busy; otherwise increment on char_tick, saturating at CTO_CHARS.
REQ-024 SHALL register cto_irq = (count==CTO_CHARS) & ~rxf_empty & fifo_en, deasserting the cycle after the clearing event.
REQ-025 SHALL give rx_push and rxf_rd priority over char_tick in the same cycle (counter cleared).

Reset
REQ-026 SHALL on rst force state IDLE, fifo_en 0, trig_lvl 00, counters 0, rxf_rd/rxf_srst/txf_srst/rda_irq/cto_irq/busy 0.
REQ-027 SHALL abort an in-progress flush on rst without emitting further srst cycles.

Configuration
REQ-028 SHALL include the timeout counter and cto_irq logic only when UART_CHAR_TIMEOUT_EN is defined; otherwise cto_irq is tied 0, char_tick is unused, and no counter is synthesized.

Structure
REQ-029 SHALL place the FSM state enum, FCR bit-position constants, and trigger-code enum in shared package uart_pkg.
REQ-030 SHALL implement the timeout counter as sub-module uart_char_timeout, instantiated under the macro.

Verification
REQ-031 SHALL test: fcr_we 8'h03 after reset -> rxf_srst high 2 cycles, txf_srst low, busy 4 cycles, fifo_en=1.
REQ-032 SHALL test: trig=10, push 7 chars then 8th (h_full rises) -> rda_irq rises 1 cycle after h_full; one rbr_re -> rxf_rd 1 cycle, rda_irq falls after h_full drops.
REQ-033 SHALL test: 2 chars in FIFO, 4 char_ticks no activity -> cto_irq high after 4th tick; rbr_re -> cto_irq low next cycle.
REQ-034 SHALL test: rbr_re with rxf_empty=1 or during FLUSH -> rxf_rd stays 0.
REQ-035 SHALL test: fcr_we 8'h05 during SETTLE of prior flush -> second FLUSH with txf_srst 2 cycles after return to IDLE boundary.
REQ-036 SHALL test: rst asserted mid-FLUSH -> srst outputs 0 immediately, state IDLE, fifo_en 0.
